fpu_seq: RTL and testbench

Multi-cycle floating-point sequencer for the core's FPU datapath. It replaces ad-hoc per-instruction stalls, such as waiting on the divider's valid, with one valid/ready request channel and one valid/ready result channel. Each operation class has a parametrised latency, and completed results are buffered in a small FIFO. It sits between the core's decode/register-read stage and the floating-point register write-back, and drives shared operand buses to the FPU IP cores (add/sub, mul, div, cmp).

---
 rtl/fpu_seq_pkg.sv | 56 +++++
 rtl/fpu_seq_fifo.sv | 56 +++++
 rtl/fpu_seq.sv | 151 +++++++++++++++
 tb/tb_fpu_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// Shared types for the FPU sequencer: opcodes, compare encoding, result entry
// and the per-op latency lookup.
package fpu_seq_pkg;

    localparam int RES_W     = 32;
    localparam int RES_TAG_W = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOV = 3'd4,
        OP_CEQ = 3'd5,
        OP_CLT = 3'd6,
        OP_CLE = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_LE = 2'd2
    } cmp_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [RES_W-1:0]     data;
        logic [RES_TAG_W-1:0] tag;
        logic                 is_cond;
    } res_entry_t;

    // Counter preload: the cycle count minus one, since the capture edge is the last one.
    function automatic int unsigned lat(input op_e op, input int unsigned add_lat,
                                        input int unsigned mul_lat, input int unsigned div_lat,
                                        input int unsigned cmp_lat);
        case (op)
            OP_MUL:                 return mul_lat - 1;
            OP_DIV:                 return div_lat - 1;
            OP_CEQ, OP_CLT, OP_CLE: return cmp_lat - 1;
            default:                return add_lat - 1;
        endcase
    endfunction

    function automatic cmp_op_e cmp_enc(input op_e op);
        case (op)
            OP_CLT:  return CMP_LT;
            OP_CLE:  return CMP_LE;
            default: return CMP_EQ;
        endcase
    endfunction

endpackage

// File: rtl/fpu_seq_fifo.sv
// Result FIFO of res_entry_t with occupancy count and a registered head entry.
module fpu_seq_fifo
    import fpu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  res_entry_t                 i_data,
    input  logic                       i_pop,
    output res_entry_t                 o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    res_entry_t        r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && o_valid && !i_flush;
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_seq.sv
// Multi-cycle FPU sequencer: one op in flight, per-class latency counter,
// results queued in a small FIFO toward write-back.
module fpu_seq
    import fpu_seq_pkg::*;
#(
    parameter int W          = 32,
    parameter int TAG_W      = 5,
    parameter int ADD_LAT    = 1,
    parameter int MUL_LAT    = 2,
    parameter int DIV_LAT    = 8,
    parameter int CMP_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    output logic [W-1:0]     fu_a,
    output logic [W-1:0]     fu_b,
    output logic             fu_sub,
    output logic [1:0]       fu_cmp_op,
    input  logic [W-1:0]     fu_add_res,
    input  logic [W-1:0]     fu_mul_res,
    input  logic [W-1:0]     fu_div_res,
    input  logic             fu_cmp_res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_is_cond,
    output logic             busy
);
    localparam int ML0     = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int ML1     = (DIV_LAT > CMP_LAT) ? DIV_LAT : CMP_LAT;
    localparam int MAX_LAT = (ML0 > ML1) ? ML0 : ML1;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1 || CMP_LAT < 1) begin : g_bad_lat
        $error("fpu_seq: every latency parameter must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fpu_seq: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (W != RES_W || TAG_W != RES_TAG_W) begin : g_bad_width
        $error("fpu_seq: W/TAG_W must match the result entry layout in fpu_seq_pkg");
    end

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    op_e               r_op;
    logic [TAG_W-1:0]  r_tag;
    logic              w_accept;
    logic              w_capture;
    logic [CW-1:0]     w_count;
    res_entry_t        w_push_entry;
    res_entry_t        w_head;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // flush overrides everything: no accept, no capture, state forced to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !flush && (w_count < DEPTH_C);
                w_accept  = req_valid && req_ready;
                if (w_accept) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_capture   = !flush;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt     <= '0;
            r_op      <= OP_ADD;
            r_tag     <= '0;
            fu_a      <= '0;
            fu_b      <= '0;
            fu_sub    <= 1'b0;
            fu_cmp_op <= CMP_EQ;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt     <= CNT_W'(lat(op_e'(req_op), ADD_LAT, MUL_LAT, DIV_LAT, CMP_LAT));
            r_op      <= op_e'(req_op);
            r_tag     <= req_tag;
            fu_a      <= req_a;
            fu_b      <= req_b;
            fu_sub    <= (op_e'(req_op) == OP_SUB);
            fu_cmp_op <= cmp_enc(op_e'(req_op));
        end else if (r_state == S_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_push_entry.data    = fu_add_res;
        w_push_entry.tag     = r_tag;
        w_push_entry.is_cond = 1'b0;
        case (r_op)
            OP_MUL: w_push_entry.data = fu_mul_res;
            OP_DIV: w_push_entry.data = fu_div_res;
            OP_MOV: w_push_entry.data = fu_b;
            OP_CEQ, OP_CLT, OP_CLE: begin
                w_push_entry.data    = {{(W-1){1'b0}}, fu_cmp_res};
                w_push_entry.is_cond = 1'b1;
            end
            default: ;
        endcase
    end

    fpu_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_flush (flush),
        .i_push  (w_capture),
        .i_data  (w_push_entry),
        .i_pop   (res_ready),
        .o_head  (w_head),
        .o_valid (res_valid),
        .o_count (w_count)
    );

    assign res_data    = w_head.data;
    assign res_tag     = w_head.tag;
    assign res_is_cond = w_head.is_cond;
    assign busy        = (r_state == S_BUSY);

endmodule

// File: tb/tb_fpu_seq.sv
// Bench for fpu_seq: stub FPU cores, a queue-based reference model checked every
// cycle, and directed scenarios with literal expectations.
module tb_fpu_seq;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_tag;
    logic [31:0] req_a, req_b;
    logic [31:0] fu_a, fu_b;
    logic        fu_sub;
    logic [1:0]  fu_cmp_op;
    logic [31:0] fu_add_res, fu_mul_res, fu_div_res;
    logic        fu_cmp_res;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_tag;
    logic        res_is_cond;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    fpu_seq dut (
        .CLK(CLK), .RST_N(RST_N), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_tag(req_tag), .req_a(req_a), .req_b(req_b),
        .fu_a(fu_a), .fu_b(fu_b), .fu_sub(fu_sub), .fu_cmp_op(fu_cmp_op),
        .fu_add_res(fu_add_res), .fu_mul_res(fu_mul_res), .fu_div_res(fu_div_res),
        .fu_cmp_res(fu_cmp_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_is_cond(res_is_cond), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Stub cores: integer stand-ins plus one real FP sum (1.0 + 2.0).
    function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return sub ? a - b : a + b;
    endfunction
    function automatic logic [31:0] f_div(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endfunction
    function automatic logic f_cmp(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            2'd0:    return a == b;
            2'd1:    return $signed(a) < $signed(b);
            2'd2:    return $signed(a) <= $signed(b);
            default: return 1'b0;
        endcase
    endfunction

    assign fu_add_res = f_add(fu_a, fu_b, fu_sub);
    assign fu_mul_res = fu_a * fu_b;
    assign fu_div_res = f_div(fu_a, fu_b);
    assign fu_cmp_res = f_cmp(fu_cmp_op, fu_a, fu_b);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        cond;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy = 0;
    int          m_left = 0;
    logic [2:0]  m_op   = 3'd0;
    logic [4:0]  m_tag  = 5'd0;
    logic [31:0] m_a    = 32'd0;
    logic [31:0] m_b    = 32'd0;

    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'd2:    return 2;
            3'd3:    return 8;
            default: return 1;
        endcase
    endfunction

    function automatic ent_t expect_of(input logic [2:0] op, input logic [4:0] tag,
                                       input logic [31:0] a, input logic [31:0] b);
        ent_t e;
        e.tag  = tag;
        e.cond = (op >= 3'd5);
        case (op)
            3'd0:    e.data = f_add(a, b, 1'b0);
            3'd1:    e.data = f_add(a, b, 1'b1);
            3'd2:    e.data = a * b;
            3'd3:    e.data = f_div(a, b);
            3'd4:    e.data = b;
            3'd5:    e.data = {31'd0, a == b};
            3'd6:    e.data = {31'd0, $signed(a) < $signed(b)};
            default: e.data = {31'd0, $signed(a) <= $signed(b)};
        endcase
        return e;
    endfunction

    // Mid-cycle: compare the DUT against model state, then step the model for the next edge.
    always @(negedge CLK) begin : model
        bit   exp_ready;
        bit   do_pop;
        bit   do_cap;
        ent_t e;
        if (!RST_N) begin
            m_q.delete();
            m_busy = 0; m_left = 0; m_op = 3'd0; m_tag = 5'd0; m_a = 32'd0; m_b = 32'd0;
        end
        exp_ready = !flush && !m_busy && (m_q.size() < DEPTH);
        chk("m_req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
        chk("m_res_valid", {31'd0, res_valid}, {31'd0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            chk("m_res_data", res_data, m_q[0].data);
            chk("m_res_tag", {27'd0, res_tag}, {27'd0, m_q[0].tag});
            chk("m_res_is_cond", {31'd0, res_is_cond}, {31'd0, m_q[0].cond});
        end
        chk("m_fu_a", fu_a, m_a);
        chk("m_fu_b", fu_b, m_b);
        chk("m_fu_sub", {31'd0, fu_sub}, {31'd0, m_op == 3'd1});
        if (m_op >= 3'd5) chk("m_fu_cmp_op", {30'd0, fu_cmp_op}, 32'(m_op - 3'd5));
        if (RST_N) begin
            if (flush) begin
                m_q.delete();
                m_busy = 0;
                m_left = 0;
            end else begin
                do_pop = res_ready && (m_q.size() > 0);
                do_cap = m_busy && (m_left == 1);
                if (do_pop) void'(m_q.pop_front());
                if (do_cap) begin
                    e = expect_of(m_op, m_tag, m_a, m_b);
                    m_q.push_back(e);
                    m_busy = 0;
                end else if (m_busy) begin
                    m_left--;
                end
                if (exp_ready && req_valid) begin
                    m_busy = 1;
                    m_left = lat_of(req_op);
                    m_op = req_op; m_tag = req_tag; m_a = req_a; m_b = req_b;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] tag,
                         input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!req_ready && n < 30) begin
            tick();
            n++;
        end
        chk("issue_wait_ready", {31'd0, req_ready}, 32'd1);
        req_op = op; req_tag = tag; req_a = a; req_b = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[6];

    initial begin
        RST_N = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_tag = 5'd0;
        req_a = 32'd0; req_b = 32'd0; res_ready = 1'b0;
        tick(); tick();
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_fu_a", fu_a, 32'd0);
        RST_N = 1'b1;
        tick();

        // ADD: result one cycle after accept
        issue(3'd0, 5'd5, 32'h3F80_0000, 32'h4000_0000);
        chk("add_busy", {31'd0, busy}, 32'd1);
        chk("add_not_yet", {31'd0, res_valid}, 32'd0);
        tick();
        chk("add_valid", {31'd0, res_valid}, 32'd1);
        chk("add_data", res_data, 32'h4040_0000);
        chk("add_tag", {27'd0, res_tag}, 32'd5);
        chk("add_cond", {31'd0, res_is_cond}, 32'd0);
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // DIV: busy and not ready for exactly 8 cycles
        issue(3'd3, 5'd6, 32'd100, 32'd7);
        for (int i = 0; i < 8; i++) begin
            chk("div_busy", {31'd0, busy}, 32'd1);
            chk("div_req_ready", {31'd0, req_ready}, 32'd0);
            chk("div_not_yet", {31'd0, res_valid}, 32'd0);
            tick();
        end
        chk("div_done_busy", {31'd0, busy}, 32'd0);
        chk("div_valid", {31'd0, res_valid}, 32'd1);
        chk("div_data", res_data, 32'd14);
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // Backpressure: four MULs fill the FIFO
        for (int i = 1; i <= 4; i++) issue(3'd2, 5'(i), 32'(i + 2), 32'd3);
        tick(); tick();
        req_op = 3'd0; req_tag = 5'd9; req_a = 32'd5; req_b = 32'd6; req_valid = 1'b1;
        chk("full_stall", {31'd0, req_ready}, 32'd0);
        tick();
        chk("full_stall2", {31'd0, req_ready}, 32'd0);
        chk("full_head_tag", {27'd0, res_tag}, 32'd1);
        chk("full_head_data", res_data, 32'd9);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        chk("pop_ready", {31'd0, req_ready}, 32'd1);
        chk("pop_head_tag", {27'd0, res_tag}, 32'd2);
        tick();
        req_valid = 1'b0;
        chk("bp_add_busy", {31'd0, busy}, 32'd1);
        tick();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_tag", {27'd0, res_tag}, (i < 3) ? 32'(i + 2) : 32'd9);
            tick();
        end
        res_ready = 1'b0;
        chk("drain_empty", {31'd0, res_valid}, 32'd0);

        // Mixed ops, model-checked
        vecs[0] = '{3'd1, 5'd7, 32'd10, 32'd3};
        vecs[1] = '{3'd4, 5'd8, 32'd1, 32'h0000_ABCD};
        vecs[2] = '{3'd5, 5'd2, 32'd5, 32'd5};
        vecs[3] = '{3'd7, 5'd4, 32'd7, 32'd7};
        vecs[4] = '{3'd6, 5'd11, 32'd7, 32'd3};
        vecs[5] = '{3'd5, 5'd12, 32'd1, 32'd2};
        res_ready = 1'b1;
        foreach (vecs[i]) issue(vecs[i].op, vecs[i].tag, vecs[i].a, vecs[i].b);
        tick(); tick();
        res_ready = 1'b0;

        // Compare CLT
        issue(3'd6, 5'd3, 32'hBF80_0000, 32'h0000_0000);
        chk("clt_cmp_op", {30'd0, fu_cmp_op}, 32'd1);
        tick();
        chk("clt_data", res_data, 32'd1);
        chk("clt_cond", {31'd0, res_is_cond}, 32'd1);
        chk("clt_tag", {27'd0, res_tag}, 32'd3);
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // Flush during BUSY with two queued results
        issue(3'd0, 5'd10, 32'd1, 32'd1);
        issue(3'd0, 5'd11, 32'd2, 32'd2);
        tick();
        issue(3'd3, 5'd12, 32'd9, 32'd3);
        tick();
        flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_tag = 5'd13;
        chk("flush_ready", {31'd0, req_ready}, 32'd0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_valid", {31'd0, res_valid}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("flush_nothing", {31'd0, res_valid | busy}, 32'd0);
            tick();
        end
        issue(3'd0, 5'd14, 32'd1, 32'd2);
        tick();
        chk("post_flush_data", res_data, 32'd3);
        chk("post_flush_tag", {27'd0, res_tag}, 32'd14);
        res_ready = 1'b1; tick(); res_ready = 1'b0;

        // Reset in the middle of a DIV
        issue(3'd3, 5'd15, 32'd50, 32'd5);
        tick(); tick();
        RST_N = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, res_valid}, 32'd0);
        tick();
        RST_N = 1'b1;
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            chk("rst_mid_no_result", {31'd0, res_valid}, 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
